// File: rtl/dot_product_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_serial_tx
//  Description : Accepts a pair of 8x8-bit vectors and streams them bit-serially
//                (A then B, LSB first) to a dot-product receiver after a
//                one-cycle Start strobe. It then waits a bounded number of
//                cycles for the receiver's Done strobe and presents the
//                returned 19-bit result, or zero with a Timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_product_serial_tx #(
   parameter int DONE_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [63:0] VecA,
   input  logic [63:0] VecB,
   input  logic        InValid,
   output logic        InReady,
   output logic        Start,
   output logic        SerialData,
   input  logic        Done,
   input  logic [18:0] DataIn,
   output logic [18:0] Result,
   output logic        ResultValid,
   output logic        Timeout,
   output logic        Busy
);

   // Timer must hold DONE_TIMEOUT itself without wrapping.
   localparam int TMR_W = (DONE_TIMEOUT < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);

   // Last timer value that still counts as "waiting"; at this value a missing
   // Done turns into a timeout. Clamped so a degenerate parameter still works.
   localparam logic [TMR_W-1:0] TMR_LAST =
      (DONE_TIMEOUT < 1) ? '0 : TMR_W'(DONE_TIMEOUT - 1);

   localparam logic [5:0] BITS_LAST = 6'd63;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_SEND_A    = 3'd2,
      ST_SEND_B    = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_RESULT    = 3'd5
   } state_t;

   state_t            state_q;
   logic [63:0]       a_sr_q;
   logic [63:0]       b_sr_q;
   logic [5:0]        bitcnt_q;
   logic [TMR_W-1:0]  timer_q;
   logic              timeout_q;
   logic [18:0]       result_q;

   // Transfer sequencer: accept, strobe, serialise A then B, await result.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         bitcnt_q  <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
         result_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Inputs are only looked at here, so changes while busy are inert.
               if (InValid) begin
                  a_sr_q  <= VecA;
                  b_sr_q  <= VecB;
                  state_q <= ST_START;
               end
            end

            ST_START: begin
               bitcnt_q <= BITS_LAST;
               state_q  <= ST_SEND_A;
            end

            ST_SEND_A: begin
               a_sr_q <= a_sr_q >> 1;
               // Test for zero before decrementing so the counter never wraps.
               if (bitcnt_q == 6'd0) begin
                  bitcnt_q <= BITS_LAST;
                  state_q  <= ST_SEND_B;
               end else begin
                  bitcnt_q <= bitcnt_q - 6'd1;
               end
            end

            ST_SEND_B: begin
               b_sr_q <= b_sr_q >> 1;
               if (bitcnt_q == 6'd0) begin
                  timer_q   <= '0;
                  timeout_q <= 1'b0;
                  state_q   <= ST_WAIT_DONE;
               end else begin
                  bitcnt_q <= bitcnt_q - 6'd1;
               end
            end

            ST_WAIT_DONE: begin
               // Done is checked first so it wins on the expiry cycle.
               if (Done) begin
                  result_q  <= DataIn;
                  timeout_q <= 1'b0;
                  state_q   <= ST_RESULT;
               end else if (timer_q == TMR_LAST) begin
                  result_q  <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_RESULT;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end

            ST_RESULT: begin
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Moore outputs: decoded purely from registered state, no input paths.
   always_comb begin
      InReady     = (state_q == ST_IDLE);
      Busy        = (state_q != ST_IDLE);
      Start       = (state_q == ST_START);
      ResultValid = (state_q == ST_RESULT);
      Timeout     = (state_q == ST_RESULT) && timeout_q;
      SerialData  = 1'b0;
      if (state_q == ST_SEND_A) begin
         SerialData = a_sr_q[0];
      end else if (state_q == ST_SEND_B) begin
         SerialData = b_sr_q[0];
      end
   end

   assign Result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dot_product_serial_tx
//  Description : Self-checking bench for dot_product_serial_tx with a
//                behavioural serial receiver and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_serial_tx;

   logic        clk = 1'b0;
   logic        Reset;
   logic [63:0] VecA, VecB;
   logic        InValid;
   logic        InReady, Start, SerialData;
   logic        Done;
   logic [18:0] DataIn;
   logic [18:0] Result;
   logic        ResultValid, Timeout, Busy;

   dot_product_serial_tx #(.DONE_TIMEOUT(16)) dut (
      .clk(clk), .Reset(Reset), .VecA(VecA), .VecB(VecB), .InValid(InValid),
      .InReady(InReady), .Start(Start), .SerialData(SerialData), .Done(Done),
      .DataIn(DataIn), .Result(Result), .ResultValid(ResultValid),
      .Timeout(Timeout), .Busy(Busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference dot product of eight unsigned byte pairs.
   function automatic logic [18:0] dot(input logic [63:0] a, input logic [63:0] b);
      logic [18:0] s;
      s = '0;
      for (int k = 0; k < 8; k++) s = s + 19'(a[8*k +: 8]) * 19'(b[8*k +: 8]);
      return s;
   endfunction

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      int          done_at;   // offset from Start cycle for Done, 0 = never
      bit          spur;      // stray Done pulse during SEND_A
      logic [18:0] exp;
      bit          exp_to;
   } vec_t;

   typedef struct {
      logic [18:0] res;
      bit          to;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   start_cnt = 0;
   int   ser_ones  = 0;
   int   rv_last   = 0;
   int   rv_prev   = 0;

   // Receiver configuration and captured stream.
   int          rx_done_at = 133;
   bit          rx_spur    = 1'b0;
   logic [63:0] rx_a = '0;
   logic [63:0] rx_b = '0;

   // Output monitor and scoreboard.
   initial begin
      exp_t e;
      int   c;
      forever begin
         @(negedge clk);
         if (!Reset && InValid && InReady) acc_q.push_back(cyc);
         if (Start) start_cnt++;
         if (SerialData) ser_ones++;
         if (Timeout && !ResultValid) begin
            n_vec++; n_bad++;
            $display("FAIL timeout_without_rv: got 1, expected 0 (cycle %0d)", cyc);
         end
         if (ResultValid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL spurious_rv: got ResultValid=1, expected 0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               c = acc_q.pop_front();
               chk("result", 64'(Result), 64'(e.res));
               chk("timeout", 64'(Timeout), 64'(e.to));
               chk("latency", 64'(cyc - c), 64'(e.lat));
               rv_prev = rv_last;
               rv_last = cyc;
            end
         end
      end
   end

   // Behavioural receiver: deserialises A and B, answers with the dot product.
   initial begin
      bit abort;
      int last_k;
      forever begin
         @(negedge clk);
         if (!Reset && Start) begin
            abort  = 1'b0;
            last_k = (rx_done_at != 0) ? rx_done_at + 1 : 145;
            for (int k = 1; k <= last_k && !abort; k++) begin
               @(negedge clk);
               if (Reset) begin
                  abort = 1'b1;
               end else begin
                  if (k <= 64) rx_a[k-1] = SerialData;
                  else if (k <= 128) rx_b[k-65] = SerialData;
                  if (rx_spur && k == 10) begin
                     Done = 1'b1; DataIn = 19'h5A5A5;
                  end else if (k == rx_done_at) begin
                     Done = 1'b1; DataIn = dot(rx_a, rx_b);
                  end else begin
                     Done = 1'b0; DataIn = '0;
                  end
               end
            end
            Done = 1'b0; DataIn = '0;
         end
      end
   end

   task automatic wait_ready(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (InReady) seen = 1'b1;
      end
      if (!seen) chk({tag, "_inready_timeout"}, 64'(0), 64'(1));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         chk({tag, "_result_missing"}, 64'(exp_q.size()), 64'(0));
         exp_q.delete();
         acc_q.delete();
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int s0, o0, lat;
      rx_done_at = v.done_at;
      rx_spur    = v.spur;
      lat = (v.done_at != 0 && v.done_at <= 144) ? v.done_at + 2 : 146;
      exp_q.push_back('{v.exp, v.exp_to, lat});
      s0 = start_cnt;
      o0 = ser_ones;
      @(posedge clk); #1;
      VecA = v.a; VecB = v.b; InValid = 1'b1;
      wait_ready(tag);
      @(posedge clk); #1;
      InValid = 1'b0;
      VecA = {$urandom, $urandom};
      VecB = {$urandom, $urandom};
      drain(tag);
      chk({tag, "_start_pulses"}, 64'(start_cnt - s0), 64'(1));
      chk({tag, "_serial_ones"}, 64'(ser_ones - o0), 64'($countones(v.a) + $countones(v.b)));
      chk({tag, "_rx_a"}, rx_a, v.a);
      chk({tag, "_rx_b"}, rx_b, v.b);
      repeat (3) @(negedge clk);
      chk({tag, "_result_hold"}, 64'(Result), 64'(v.exp));
   endtask

   initial begin
      vec_t        tbl[9];
      vec_t        v;
      logic [63:0] ra, rb;

      Reset = 1'b1; InValid = 1'b0; VecA = '0; VecB = '0; Done = 1'b0; DataIn = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_inready", 64'(InReady), 64'(1));
      chk("rst_busy", 64'(Busy), 64'(0));
      chk("rst_start", 64'(Start), 64'(0));
      chk("rst_serial", 64'(SerialData), 64'(0));
      chk("rst_rv", 64'(ResultValid), 64'(0));
      chk("rst_timeout", 64'(Timeout), 64'(0));
      chk("rst_result", 64'(Result), 64'(0));
      @(posedge clk); #1;
      Reset = 1'b0;

      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      tbl[0] = '{64'h0101010101010101, 64'h0101010101010101, 133, 1'b0, 19'd8,     1'b0};
      tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 133, 1'b0, 19'h7F008, 1'b0};
      tbl[2] = '{64'h0000000000000001, 64'h8000000000000000, 133, 1'b0, 19'd0,     1'b0};
      tbl[3] = '{64'h0102030405060708, 64'h0807060504030201, 133, 1'b0, 19'd120,   1'b0};
      tbl[4] = '{ra,                   rb,                   133, 1'b0, dot(ra, rb), 1'b0};
      tbl[5] = '{64'h0101010101010101, 64'h0101010101010101, 0,   1'b1, 19'd0,     1'b1};
      tbl[6] = '{64'h1010101010101010, 64'h0303030303030303, 144, 1'b0, 19'd384,   1'b0};
      tbl[7] = '{64'h1010101010101010, 64'h0303030303030303, 145, 1'b0, 19'd0,     1'b1};
      tbl[8] = '{rb,                   ra,                   133, 1'b1, dot(ra, rb), 1'b0};

      for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("row%0d", i));

      // Two pairs offered back to back with InValid held high.
      rx_done_at = 133; rx_spur = 1'b0;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      exp_q.push_back('{19'd48, 1'b0, 135});
      exp_q.push_back('{dot(ra, rb), 1'b0, 135});
      @(posedge clk); #1;
      VecA = 64'h0202020202020202; VecB = 64'h0303030303030303; InValid = 1'b1;
      wait_ready("b2b_first");
      @(posedge clk); #1;
      VecA = ra; VecB = rb;
      wait_ready("b2b_second");
      @(posedge clk); #1;
      InValid = 1'b0;
      drain("b2b");
      chk("b2b_rv_spacing", 64'(rv_last - rv_prev), 64'(136));

      // Reset in the middle of SEND_A.
      begin
         bit seen;
         rx_done_at = 133; rx_spur = 1'b0;
         @(posedge clk); #1;
         VecA = {$urandom, $urandom}; VecB = {$urandom, $urandom}; InValid = 1'b1;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (Start) seen = 1'b1;
         end
         chk("abort_start_seen", 64'(seen), 64'(1));
         for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i == 0) InValid = 1'b0;
         end
         Reset = 1'b1;
         @(negedge clk);
         @(negedge clk);
         chk("abort_start", 64'(Start), 64'(0));
         chk("abort_serial", 64'(SerialData), 64'(0));
         chk("abort_busy", 64'(Busy), 64'(0));
         chk("abort_inready", 64'(InReady), 64'(1));
         chk("abort_result", 64'(Result), 64'(0));
         @(posedge clk); #1;
         Reset = 1'b0;
         exp_q.delete();
         acc_q.delete();
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         v = '{ra, rb, 133, 1'b0, dot(ra, rb), 1'b0};
         run_vec(v, "post_abort");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Global watchdog against a hung run.
   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/dot_product_serial_tx.md
DOT_PRODUCT_SERIAL_TX -- requirements
Module: dot_product_serial_tx

Interface
REQ-001 Parameter DONE_TIMEOUT, default 16: number of WAIT_DONE cycles allowed for Done before the timeout response.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous reset, active-high.
REQ-004 VecA  input  64  vector A, eight unsigned 8-bit elements, element k at [8k+7:8k].
REQ-005 VecB  input  64  vector B, same packing as VecA.
REQ-006 InValid  input  1  VecA/VecB valid.
REQ-007 InReady  output  1  block can accept a vector pair.
REQ-008 Start  output  1  one-cycle start strobe to the dot-product receiver.
REQ-009 SerialData  output  1  serial bit stream to the receiver.
REQ-010 Done  input  1  completion strobe from the receiver.
REQ-011 DataIn  input  19  dot-product result from the receiver, valid while Done=1.
REQ-012 Result  output  19  captured dot product.
REQ-013 ResultValid  output  1  one-cycle pulse: Result updated.
REQ-014 Timeout  output  1  one-cycle pulse, coincident with ResultValid, when Done never arrived.
REQ-015 Busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, START, SEND_A, SEND_B, WAIT_DONE, RESULT; InReady, Start, SerialData, ResultValid, Timeout and Busy SHALL be decoded from registered state only (Moore, no input-to-output paths).
REQ-017 IDLE: InReady=1; accept on InValid&InReady in cycle C; latch VecA/VecB into 64-bit shift registers; go to START.
REQ-018 START (cycle C+1, call it S): Start=1, SerialData=0; load 6-bit bit counter with 63; go to SEND_A.
REQ-019 SEND_A (cycles S+1..S+64): SerialData = A shift reg bit 0, LSB first (A[0] in S+1, A[63] in S+64); shift right and decrement the counter each cycle; at counter=0 reload 63 and go to SEND_B.
REQ-020 SEND_B (cycles S+65..S+128): same as SEND_A for B; at counter=0 clear the timeout timer and go to WAIT_DONE.
REQ-021 In all states other than SEND_A/SEND_B, SerialData SHALL be 0; Start SHALL be 1 only in START.
REQ-022 WAIT_DONE: if Done=1, capture DataIn into Result and go to RESULT; otherwise increment the timer; after DONE_TIMEOUT cycles without Done, set Result=0, set the timeout flag and go to RESULT.
REQ-023 If Done=1 occurs in the same cycle the timer expires, Done SHALL win (capture, no Timeout).
REQ-024 Done asserted in any state other than WAIT_DONE SHALL be ignored.
REQ-025 RESULT: ResultValid=1 for exactly one cycle, Timeout=timeout flag, then go to IDLE; Result SHALL hold its value until the next capture or timeout.
REQ-026 With a compliant receiver (Done in S+133), ResultValid SHALL assert in cycle S+134 (C+135), and InReady SHALL reassert in C+136.
REQ-027 While Busy=1, InReady=0, and VecA/VecB/InValid changes SHALL have no effect.
REQ-028 The timer SHALL be wide enough to hold DONE_TIMEOUT without wrap; the bit counter SHALL never wrap below 0.

Reset
REQ-029 While Reset=1 at a rising edge: state=IDLE; shift registers, counters, timeout flag and Result=0; outputs Start=0, SerialData=0, ResultValid=0, Timeout=0, Busy=0, InReady=1 from the next cycle.
REQ-030 Reset mid-transfer SHALL abort immediately with no further Start or data bits; the receiver is on the same Reset.

Verification
REQ-031 All elements of A and B 0x01, compliant receiver -> Result=19'd8, ResultValid in C+135, Timeout=0.
REQ-032 All elements 0xFF -> Result=19'h7F008 (520200), no overflow.
REQ-033 VecA=64'h1, VecB=64'h8000_0000_0000_0000 -> SerialData=1 only in S+1 and S+128; Start=1 only in S.
REQ-034 Done held 0 -> Timeout=1 and ResultValid=1 in WAIT_DONE entry+16, Result=0; Done pulsed in SEND_A ignored.
REQ-035 Reset=1 at cycle S+30 -> next cycle Start=0, SerialData=0, Busy=0, InReady=1; a new transfer then completes correctly.
REQ-036 InValid held 1 with two different pairs -> second pair accepted in C+136, two ResultValid pulses 136 cycles apart with correct sums.
